// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
//==============================================================================
// uart_rx_ctrl_if : bus-side handshake/status bundle of uart_rx_ctrl
//                   (parity_err present only with UART_RX_PARITY_EN)
// Revision        : 1.0 - initial release
//==============================================================================
interface uart_rx_ctrl_if;
  logic       enable;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output enable, rd_en, err_clr,
                  input  rx_data, rx_valid, busy, frame_err, overrun, parity_err);
  modport slave  (input  enable, rd_en, err_clr,
                  output rx_data, rx_valid, busy, frame_err, overrun, parity_err);
`else
  modport master (output enable, rd_en, err_clr,
                  input  rx_data, rx_valid, busy, frame_err, overrun);
  modport slave  (input  enable, rd_en, err_clr,
                  output rx_data, rx_valid, busy, frame_err, overrun);
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
//==============================================================================
// uart_rx_ctrl : 16x oversampled 8N1 UART receiver with FWFT byte FIFO
//                optional even-parity frame via UART_RX_PARITY_EN
// Revision     : 1.0 - initial release
//==============================================================================
module uart_rx_ctrl #(
  parameter int DIV        = 651,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          UART_RX,
  uart_rx_ctrl_if.slave bus
);
  localparam int              CW       = $clog2(DIV);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT1     = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic          sync1, sync2, rx_s;
  logic [CW-1:0] cnt;
  logic          tick, start_det;
  state_t        state, state_d;
  logic [3:0]    osc, osc_d;
  logic [2:0]    bitcnt, bitcnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          push, frame_set, overrun_set;
  logic          frame_err_q, overrun_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, full, wr;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_d, parity_set, parity_err_q;
`endif

  assign rx_s = sync2;
  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= UART_RX;
      sync2 <= sync1;
      // realign the oversample grid to the detected start edge
      cnt   <= (start_det || tick) ? '0 : cnt + CNT_ONE;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      osc    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      osc    <= osc_d;
      bitcnt <= bitcnt_d;
      shreg  <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    osc_d     = osc;
    bitcnt_d  = bitcnt;
    shreg_d   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    start_det = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad;
    parity_set = 1'b0;
`endif
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (!rx_s) begin
          state_d   = START;
          osc_d     = '0;
          start_det = 1'b1;
        end
        START: if (tick) begin
          if (osc == 4'd7) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d  = DATA;
              osc_d    = '0;
              bitcnt_d = '0;
            end
          end else begin
            osc_d = osc + 4'd1;
          end
        end
        DATA: if (tick) begin
          osc_d = osc + 4'd1;
          if (osc == 4'd15) begin
            shreg_d  = {rx_s, shreg[7:1]};
            bitcnt_d = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              osc_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          osc_d = osc + 4'd1;
          if (osc == 4'd15) begin
            // even parity: the nine bits must carry an even number of ones
            par_bad_d  = ^{shreg, rx_s};
            parity_set = ^{shreg, rx_s};
            osc_d      = '0;
            state_d    = STOP;
          end
        end
`endif
        STOP: if (tick) begin
          osc_d = osc + 4'd1;
          if (osc == 4'd15) begin
            state_d = IDLE;
            if (!rx_s) begin
              frame_set = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad;
`else
              push = 1'b1;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop         = bus.rd_en && (count != '0);
  assign full        = (count == FULL_CNT);
  assign wr          = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr, pop})
        2'b10:   count <= count + CNT1;
        2'b01:   count <= count - CNT1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= frame_set   || (frame_err_q && !bus.err_clr);
      overrun_q   <= overrun_set || (overrun_q   && !bus.err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_set || (parity_err_q && !bus.err_clr);
`endif
    end
  end

  assign bus.rx_data   = mem[rd_ptr];
  assign bus.rx_valid  = (count != '0);
  assign bus.busy      = (state != IDLE);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
//==============================================================================
// tb_uart_rx_ctrl : randomized self-checking bench against a queue model
// Revision        : 1.0 - initial release
//==============================================================================
module tb_uart_rx_ctrl;
  localparam int DIV      = 4;
  localparam int DEPTH    = 4;
  localparam int BITCLK   = 16 * DIV;
  localparam int FRAME    = 10 * BITCLK;
  // clock index (from start-bit drive) of the edge that samples the stop bit
  localparam int SAMPLE_C = 2 + (8 + 8 * 16 + 16) * DIV;

  logic sysclk  = 1'b0;
  logic reset   = 1'b1;
  logic UART_RX = 1'b1;

  uart_rx_ctrl_if bus_if ();

  uart_rx_ctrl #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .UART_RX (UART_RX),
    .bus     (bus_if)
  );

  always #5 sysclk = ~sysclk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;
  int         rise_at;
  logic [7:0] popped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, bus_if.rx_valid, (q.size() != 0));
    if (q.size() != 0) check({tag, ".data"}, bus_if.rx_data, q[0]);
    check({tag, ".ferr"}, bus_if.frame_err, m_ferr);
    check({tag, ".ovr"},  bus_if.overrun,   m_ovr);
    check({tag, ".busy"}, bus_if.busy,      1'b0);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop, input int ncyc, input int pop_at);
    logic [9:0] f;
    logic       prev;
    f       = {stop, b, 1'b0};
    prev    = bus_if.rx_valid;
    rise_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      UART_RX      = f[c / BITCLK];
      bus_if.rd_en = (c == pop_at);
      if (c == pop_at) popped = bus_if.rx_data;
      @(posedge sysclk);
      #1;
      if (rise_at < 0 && !prev && bus_if.rx_valid) rise_at = c;
      prev = bus_if.rx_valid;
    end
    bus_if.rd_en = 1'b0;
    UART_RX      = 1'b1;
  endtask

  task automatic model_pop(input string tag);
    if (q.size() != 0) begin
      check(tag, popped, q[0]);
      void'(q.pop_front());
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input logic stop, input int pop_at);
    send_bits(b, stop, FRAME, pop_at);
    if (pop_at >= 0 && pop_at <= SAMPLE_C) model_pop({tag, ".inpop"});
    if (!stop)                 m_ferr = 1'b1;
    else if (q.size() < DEPTH) q.push_back(b);
    else                       m_ovr = 1'b1;
    if (pop_at > SAMPLE_C) model_pop({tag, ".inpop"});
    cycles(80);
    check_state(tag);
  endtask

  task automatic pop_one(input string tag);
    if (q.size() != 0) begin
      check(tag, bus_if.rx_data, q[0]);
      void'(q.pop_front());
    end
    bus_if.rd_en = 1'b1;
    cycles(1);
    bus_if.rd_en = 1'b0;
  endtask

  task automatic clear_err();
    bus_if.err_clr = 1'b1;
    cycles(1);
    bus_if.err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    bus_if.enable  = 1'b1;
    bus_if.rd_en   = 1'b0;
    bus_if.err_clr = 1'b0;
    popped         = '0;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    check("reset.data", bus_if.rx_data, 8'h00);
    check_state("reset");

    // single byte, exact rx_valid timing, then pop
    frame("a5", 8'hA5, 1'b1, -1);
    check("a5.rise", rise_at, SAMPLE_C);
    pop_one("a5.pop");
    check_state("a5.after_pop");

    // rd_en on empty FIFO is ignored
    pop_one("empty_rd");
    check_state("empty_rd");

    // short low glitch
    UART_RX = 1'b0;
    cycles(20);
    UART_RX = 1'b1;
    cycles(5);
    check("glitch.busy", bus_if.busy, 1'b1);
    cycles(60);
    check_state("glitch");

    // framing error and clear
    frame("3c", 8'h3C, 1'b0, -1);
    clear_err();
    check_state("3c.clr");

    // overrun: five bytes without reads
    for (int i = 1; i <= 5; i++) frame("fill5", 8'(i), 1'b1, -1);
    for (int i = 0; i < 4; i++) pop_one("fill5.pop");
    check_state("fill5.empty");

    // full FIFO with pop on the exact push edge
    clear_err();
    for (int i = 1; i <= 4; i++) frame("fill4", 8'(i), 1'b1, -1);
    frame("b66", 8'h66, 1'b1, SAMPLE_C);
    for (int i = 0; i < 4; i++) pop_one("b66.pop");
    check_state("b66.empty");

    // enable dropped mid-frame keeps FIFO contents and flags
    frame("keep", 8'hC3, 1'b1, -1);
    send_bits(8'h0F, 1'b1, 2 * BITCLK + 20, -1);
    bus_if.enable = 1'b0;
    cycles(1);
    check("en_drop.busy", bus_if.busy, 1'b0);
    cycles(80);
    bus_if.enable = 1'b1;
    cycles(10);
    check_state("en_drop");

    // randomized frames, reads, in-frame pops and flag clears
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       stop;
      int         pa;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      pa   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
      frame("rnd", b, stop, pa);
      repeat ($urandom_range(0, 2)) pop_one("rnd.pop");
      if ($urandom_range(0, 3) == 0) clear_err();
      check_state("rnd.post");
    end

    // reset after three data bits
    if (q.size() == 0) frame("pre_rst", 8'h81, 1'b1, -1);
    send_bits(8'hE7, 1'b1, 4 * BITCLK, -1);
    UART_RX = 1'b0;
    reset   = 1'b1;
    #1;
    check("rst.valid", bus_if.rx_valid, 1'b0);
    check("rst.data",  bus_if.rx_data,  8'h00);
    check("rst.ferr",  bus_if.frame_err, 1'b0);
    check("rst.ovr",   bus_if.overrun,  1'b0);
    UART_RX = 1'b1;
    cycles(1);
    check("rst.busy", bus_if.busy, 1'b0);
    cycles(2);
    reset = 1'b0;
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    cycles(5);
    check_state("rst.idle");
    frame("5a", 8'h5A, 1'b1, -1);
    check("5a.data", bus_if.rx_data, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
